// File: rtl/legv8_store_serializer.sv
// rtl/legv8_store_serializer.sv - posts LEGv8 64-bit stores into a FIFO and drains them as 16-bit beats
module legv8_store_serializer #(
  parameter int DEPTH  = 4,
  parameter int EXT_AW = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [63:0]              address,
  input  logic [63:0]              data,
  input  logic                     M_Write,
  input  logic                     En_Ram,
  output logic [EXT_AW-1:0]        ext_addr,
  output logic [15:0]              ext_data,
  output logic                     ext_we,
  input  logic                     ext_ack,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     full,
  output logic                     overflow,
  output logic                     idle
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = EXT_AW - 2;
  localparam int EW = WW + 64;

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t          state, state_next;
  logic [1:0]      beat, beat_next;
  logic [EW-1:0]   mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_next;
  logic [EW-1:0]   head;
  logic            push, pop, accept, at_full;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^{address[63:EXT_AW+1], address[2:0]};

  assign head    = mem[rd_ptr];
  assign at_full = (count == CW'(DEPTH));
  assign push    = En_Ram & M_Write;
  assign pop     = (state == S_SEND) && (beat == 2'd3) && ext_ack;
  // A full FIFO still takes a store when the head leaves at the same edge.
  assign accept  = push && (!at_full || pop);

  always_comb begin
    count_next = count;
    case ({accept, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      mem[wr_ptr] <= {address[EXT_AW:3], data};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      beat     <= 2'd0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      beat  <= beat_next;
      count <= count_next;
      if (accept) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !accept) begin
        overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    beat_next  = beat;
    ext_we     = 1'b0;
    ext_addr   = '0;
    ext_data   = '0;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          state_next = S_SEND;
          beat_next  = 2'd0;
        end
      end
      S_SEND: begin
        ext_we   = 1'b1;
        ext_addr = {head[EW-1:64], beat};
        case (beat)
          2'd0:    ext_data = head[15:0];
          2'd1:    ext_data = head[31:16];
          2'd2:    ext_data = head[47:32];
          default: ext_data = head[63:48];
        endcase
        if (ext_ack) begin
          beat_next = beat + 2'd1;
          // Continue straight into the next entry so the port sees no gap.
          if (beat == 2'd3 && count_next == '0) begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign fifo_count = count;
  assign full       = at_full;
  assign idle       = (state == S_IDLE) && (count == '0);

endmodule

// File: tb/tb_legv8_store_serializer.sv
// tb/tb_legv8_store_serializer.sv - scoreboard bench for legv8_store_serializer
module tb_legv8_store_serializer;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] address;
  logic [63:0] data;
  logic        M_Write;
  logic        En_Ram;
  logic [15:0] ext_addr;
  logic [15:0] ext_data;
  logic        ext_we;
  logic        ext_ack;
  logic [2:0]  fifo_count;
  logic        full;
  logic        overflow;
  logic        idle;

  int n_checks = 0;
  int n_pass   = 0;
  int beat_count = 0;
  logic [31:0] exp_q [$];

  legv8_store_serializer #(.DEPTH(4), .EXT_AW(16)) dut (
    .clock(clock), .reset(reset), .address(address), .data(data),
    .M_Write(M_Write), .En_Ram(En_Ram), .ext_addr(ext_addr), .ext_data(ext_data),
    .ext_we(ext_we), .ext_ack(ext_ack), .fifo_count(fifo_count), .full(full),
    .overflow(overflow), .idle(idle)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input logic [63:0] a, input logic [63:0] d);
    for (int b = 0; b < 4; b++) begin
      logic [1:0] bb;
      bb = 2'(b);
      exp_q.push_back({a[16:3], bb, d[16*b +: 16]});
    end
  endtask

  task automatic store(input logic [63:0] a, input logic [63:0] d);
    address = a;
    data    = d;
    En_Ram  = 1'b1;
    M_Write = 1'b1;
    tick();
    En_Ram  = 1'b0;
    M_Write = 1'b0;
  endtask

  task automatic do_reset();
    exp_q.delete();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!idle && n < 200) begin
      tick();
      n++;
    end
    check(name, idle, 1'b1);
  endtask

  // Scoreboard monitor: each accepted beat must match the oldest expected beat.
  always @(negedge clock) begin
    if (!reset && ext_we && ext_ack) begin
      beat_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {ext_addr, ext_data}, 32'h0);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("beat_addr", ext_addr, e[31:16]);
        check("beat_data", ext_data, e[15:0]);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; address = '0; data = '0; M_Write = 1'b0; En_Ram = 1'b0; ext_ack = 1'b0;
    tick();
    do_reset();
    check("rst_we", ext_we, 0);
    check("rst_addr", ext_addr, 0);
    check("rst_data", ext_data, 0);
    check("rst_count", fifo_count, 0);
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_idle", idle, 1);

    // Single store with ack tied high: beats in cycles 2-5.
    ext_ack = 1'b1;
    exp_q.push_back({16'h0014, 16'h4444});
    exp_q.push_back({16'h0015, 16'h3333});
    exp_q.push_back({16'h0016, 16'h2222});
    exp_q.push_back({16'h0017, 16'h1111});
    store(64'h28, 64'h1111_2222_3333_4444);
    check("t1_c1_we", ext_we, 0);
    check("t1_c1_count", fifo_count, 1);
    for (int c = 2; c <= 5; c++) begin
      tick();
      check($sformatf("t1_c%0d_we", c), ext_we, 1);
    end
    tick();
    check("t1_c6_we", ext_we, 0);
    check("t1_c6_idle", idle, 1);
    check("t1_q_empty", exp_q.size(), 0);

    // Five back-to-back stores with ack low: fifth dropped.
    ext_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      logic [63:0] a, d;
      a = 64'h1000 + 64'(i * 8);
      d = {16'(16'hA000 + i), 16'(16'hB000 + i), 16'(16'hC000 + i), 16'(16'hD000 + i)};
      if (i < 4) push_exp(a, d);
      store(a, d);
      if (i == 3) begin
        check("t2_count4", fifo_count, 4);
        check("t2_full", full, 1);
        check("t2_ovf_before", overflow, 0);
      end
    end
    check("t2_count_after", fifo_count, 4);
    check("t2_ovf", overflow, 1);
    beat_count = 0;
    ext_ack = 1'b1;
    wait_idle("t2_idle");
    check("t2_beats", beat_count, 16);
    check("t2_ovf_sticky", overflow, 1);

    // Wait states on beat 1.
    do_reset();
    ext_ack = 1'b0;
    push_exp(64'h100, 64'hAAAA_BBBB_CCCC_DDDD);
    store(64'h100, 64'hAAAA_BBBB_CCCC_DDDD);
    tick();
    check("t3_we", ext_we, 1);
    check("t3_b0_addr", ext_addr, 16'h0080);
    ext_ack = 1'b1;
    tick();
    ext_ack = 1'b0;
    for (int w = 0; w < 3; w++) begin
      check("t3_hold_addr", ext_addr, 16'h0081);
      check("t3_hold_data", ext_data, 16'hCCCC);
      check("t3_hold_we", ext_we, 1);
      tick();
    end
    ext_ack = 1'b1;
    tick();
    check("t3_b2_addr", ext_addr, 16'h0082);
    check("t3_b2_data", ext_data, 16'hBBBB);
    wait_idle("t3_idle");

    // Full FIFO with a store landing on the beat-3 ack.
    ext_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [63:0] a, d;
      a = 64'h2000 + 64'(i * 8);
      d = {4{16'(16'h5000 + i)}};
      push_exp(a, d);
      store(a, d);
    end
    check("t4_full", full, 1);
    ext_ack = 1'b1;
    tick();
    tick();
    tick();
    check("t4_b3_addr", ext_addr, 16'h1003);
    push_exp(64'h2040, 64'h0123_4567_89AB_CDEF);
    store(64'h2040, 64'h0123_4567_89AB_CDEF);
    check("t4_count", fifo_count, 4);
    check("t4_ovf", overflow, 0);
    wait_idle("t4_idle");
    check("t4_q_empty", exp_q.size(), 0);

    // Reads and unqualified strobes are ignored.
    En_Ram = 1'b1;
    M_Write = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("t5_count", fifo_count, 0);
      check("t5_we", ext_we, 0);
    end
    En_Ram = 1'b0;
    M_Write = 1'b1;
    tick();
    tick();
    check("t5_mw_count", fifo_count, 0);
    M_Write = 1'b0;

    // Reset during beat 2 with two entries queued.
    ext_ack = 1'b0;
    push_exp(64'h3000, 64'h1234_5678_9ABC_DEF0);
    store(64'h3000, 64'h1234_5678_9ABC_DEF0);
    store(64'h3008, 64'h0FED_CBA9_8765_4321);
    ext_ack = 1'b1;
    tick();
    tick();
    check("t6_b2_addr", ext_addr, 16'h1802);
    check("t6_count", fifo_count, 2);
    ext_ack = 1'b0;
    do_reset();
    check("t6_we", ext_we, 0);
    check("t6_count0", fifo_count, 0);
    check("t6_ovf", overflow, 0);
    check("t6_idle", idle, 1);
    ext_ack = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("t6_no_resume", ext_we, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/legv8_store_serializer.md
Name: legv8_store_serializer

Overview:
- Sits directly downstream of the LEGv8 processor top.
- Consumes its data-memory bus (address, data, M_Write, En_Ram) and posts every 64-bit store into a small write FIFO.
- Drains each FIFO entry to a 16-bit external RAM port as four halfword beats under a req/ack handshake.
- The processor never stalls. Stores arriving while the FIFO is full are dropped and flagged.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- EXT_AW, 16, external halfword address width; at least 4.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- address  input  64  processor byte address; bits [2:0] ignored.
- data  input  64  processor store data.
- M_Write  input  1  processor store strobe.
- En_Ram  input  1  processor RAM enable.
- ext_addr  output  EXT_AW  external halfword address.
- ext_data  output  16  external write data.
- ext_we  output  1  external write request.
- ext_ack  input  1  external write accept.
- fifo_count  output  $clog2(DEPTH)+1  entries held.
- full  output  1  fifo_count == DEPTH.
- overflow  output  1  sticky; a store was dropped.
- idle  output  1  FIFO empty and FSM in IDLE.

Behaviour:
- Reset (synchronous, active-high, clock edge): all outputs go to zero (ext_we=0, ext_addr=0, ext_data=0, fifo_count=0, full=0, overflow=0) except idle=1. FSM goes to IDLE, beat=0.
- Reset mid-burst aborts the burst: FIFO contents are discarded, and ext_we is 0 in the cycle after the reset edge.
- Push condition: En_Ram && M_Write sampled high at an edge. Each such cycle is one distinct store.
- Pushed entry: {address[EXT_AW:3], data}.
- En_Ram high with M_Write low is a read and is ignored. M_Write high without En_Ram is ignored.
- Push acceptance: accepted if fifo_count < DEPTH, or if a pop occurs at the same edge. In that case the count is unchanged.
- Push rejection: otherwise the store is dropped, overflow is set to 1, and overflow stays 1 until reset.
- Pop: occurs at the edge where beat 3 is acknowledged.
- FSM, IDLE -> SEND: taken at the edge where the FSM is in IDLE and fifo_count > 0. beat=0 on entry.
  - A store pushed into an empty FIFO at edge E0 gives ext_we=1 from edge E1.
- FSM, SEND: ext_we=1 and outputs are driven from the head entry:
  - ext_addr = {head_addr[EXT_AW-2:0-relative index bits], beat}, i.e. the stored word index concatenated with beat[1:0].
  - ext_data = head_data[16*beat+15 : 16*beat], little-endian; beat 0 is the low halfword.
- Handshake:
  - A beat completes at an edge where ext_we && ext_ack.
  - ext_addr, ext_data and ext_we hold stable until completion.
  - ext_ack is ignored while ext_we=0.
  - With ext_ack tied high the port moves one beat per cycle.
- After the beat-3 ack: pop. If entries remain after the pop, stay in SEND with beat=0 on the next entry and no idle gap. Otherwise go to IDLE.
- Wait states: any number of ext_ack-low cycles is legal, and no timeout is applied.
- Wrap-around: FIFO read/write pointers wrap modulo DEPTH. ext_addr truncates the upper address bits silently.

Test Plan:
- Single store, ext_ack tied 1:
  - Stimulus: address=0x28, data=0x1111_2222_3333_4444 in cycle 0.
  - Response: ext_we high cycles 2-5 with ext_addr=0x14,0x15,0x16,0x17 and ext_data=0x4444,0x3333,0x2222,0x1111.
  - Response: ext_we=0 and idle=1 in cycle 6.
- Back-to-back stores with ack=0:
  - Stimulus: 5 stores in consecutive cycles, DEPTH=4.
  - Response: fifo_count reaches 4 and full=1; the 5th store is dropped and overflow=1.
  - Response: after ack is raised, exactly 16 beats follow, then idle=1. overflow stays 1.
- Wait states:
  - Stimulus: ext_ack low for 3 cycles on beat 1.
  - Response: ext_addr and ext_data hold the beat-1 values. Beat 2 appears the cycle after ack.
- Full plus simultaneous pop:
  - Stimulus: FIFO full, a store arrives at the same edge as the beat-3 ack.
  - Response: store accepted, fifo_count stays 4, overflow=0.
- Reads ignored:
  - Stimulus: En_Ram=1 with M_Write=0 for 10 cycles.
  - Response: fifo_count=0 and ext_we=0 throughout.
- Reset mid-burst:
  - Stimulus: reset during beat 2 with 2 entries queued.
  - Response: next cycle ext_we=0, fifo_count=0, overflow=0, idle=1. The previous data never resumes.
